keccak_buffer_gen: RTL

Parametrised absorb/squeeze buffer between the message interface and the Keccak permutation core. It packs IN_W-bit input words into a RATE_W-bit block for absorption. After the last block it captures the DIGEST_W-bit digest and emits it as OUT_W-bit words. Unlike the fixed-size buffer, it supports any SHA-3 rate, valid/ready backpressure on both sides, and explicit last-word marking.

---
 rtl/keccak_buffer_gen_pkg.sv | 27 ++
 rtl/keccak_buffer_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/keccak_buffer_gen_pkg.sv
// Shared constants and types for the Keccak absorb/squeeze buffer.
// Rates follow the SHA-3 capacity choices for each digest length.
package keccak_buffer_gen_pkg;

    localparam int RATE_224 = 1152;
    localparam int RATE_256 = 1088;
    localparam int RATE_384 = 832;
    localparam int RATE_512 = 576;

    localparam int IN_W_DEF     = 64;
    localparam int RATE_W_DEF   = RATE_256;
    localparam int OUT_W_DEF    = 64;
    localparam int DIGEST_W_DEF = 256;

    typedef enum logic [1:0] {
        FILL        = 2'd0,
        FULL        = 2'd1,
        WAIT_DIGEST = 2'd2,
        DRAIN       = 2'd3
    } buf_state_t;

    // Width of a counter that must be able to hold the value n.
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/keccak_buffer_gen.sv
// Absorb/squeeze buffer: packs message words into a rate block for the
// permutation core, then captures the digest and streams it out word by word.
module keccak_buffer_gen
    import keccak_buffer_gen_pkg::*;
#(
    parameter int IN_W     = IN_W_DEF,
    parameter int RATE_W   = RATE_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int DIGEST_W = DIGEST_W_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [IN_W-1:0]     Din_buffer_in,
    input  logic                Din_buffer_in_valid,
    output logic                Din_buffer_in_ready,
    input  logic                Last_block,
    output logic                Din_buffer_full,
    output logic [RATE_W-1:0]   Din_buffer_out,
    output logic                Din_buffer_last,
    input  logic                Din_buffer_take,
    input  logic [DIGEST_W-1:0] Dout_buffer_in,
    input  logic                Dout_buffer_in_valid,
    output logic [OUT_W-1:0]    Dout_buffer_out,
    output logic                Dout_buffer_out_valid,
    input  logic                Dout_buffer_out_ready,
    output logic                Dout_buffer_out_last
);

    localparam int IN_WORDS  = RATE_W / IN_W;
    localparam int OUT_WORDS = DIGEST_W / OUT_W;
    localparam int ICW       = count_w(IN_WORDS);
    localparam int OCW       = count_w(OUT_WORDS);

    localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_WORDS - 1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_WORDS - 1);

    if (RATE_W % IN_W != 0) begin : g_bad_in_w
        $error("keccak_buffer_gen: RATE_W must be a multiple of IN_W");
    end
    if (DIGEST_W % OUT_W != 0) begin : g_bad_out_w
        $error("keccak_buffer_gen: DIGEST_W must be a multiple of OUT_W");
    end
    if (DIGEST_W > RATE_W) begin : g_bad_digest_w
        $error("keccak_buffer_gen: DIGEST_W must not exceed RATE_W");
    end

    buf_state_t        state_q, state_d;
    logic [RATE_W-1:0] buf_q, buf_d;
    logic [ICW-1:0]    in_count_q, in_count_d;
    logic [OCW-1:0]    out_count_q, out_count_d;
    logic              last_flag_q, last_flag_d;
    logic              out_valid_q, out_valid_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= FILL;
            buf_q       <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            last_flag_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            last_flag_q <= last_flag_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        in_count_d  = in_count_q;
        out_count_d = out_count_q;
        last_flag_d = last_flag_q;

        case (state_q)
            FILL: begin
                if (Din_buffer_in_valid) begin
                    // New words enter at the top so the first word ends up in the LSBs.
                    buf_d = buf_q >> IN_W;
                    buf_d[RATE_W-1 -: IN_W] = Din_buffer_in;
                    last_flag_d = last_flag_q | Last_block;
                    if (in_count_q == IN_LAST) begin
                        in_count_d = '0;
                        state_d    = FULL;
                    end else begin
                        in_count_d = in_count_q + ICW'(1);
                    end
                end
            end

            FULL: begin
                if (Din_buffer_take) begin
                    if (last_flag_q) begin
                        last_flag_d = 1'b0;
                        state_d     = WAIT_DIGEST;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            WAIT_DIGEST: begin
                if (Dout_buffer_in_valid) begin
                    buf_d[DIGEST_W-1:0] = Dout_buffer_in;
                    out_count_d         = '0;
                    state_d             = DRAIN;
                end
            end

            DRAIN: begin
                if (Dout_buffer_out_ready) begin
                    if (out_count_q == OUT_LAST) begin
                        buf_d       = '0;
                        out_count_d = '0;
                        state_d     = FILL;
                    end else begin
                        buf_d       = buf_q >> OUT_W;
                        out_count_d = out_count_q + OCW'(1);
                    end
                end
            end

            default: state_d = FILL;
        endcase

        out_valid_d = (state_d == DRAIN);
    end

    assign Din_buffer_in_ready   = (state_q == FILL);
    assign Din_buffer_full       = (state_q == FULL);
    assign Din_buffer_last       = (state_q == FULL) && last_flag_q;
    assign Din_buffer_out        = buf_q;
    assign Dout_buffer_out_valid = out_valid_q;
    assign Dout_buffer_out       = out_valid_q ? buf_q[OUT_W-1:0] : '0;
    assign Dout_buffer_out_last  = out_valid_q && (out_count_q == OUT_LAST);

endmodule
